genie_conv_rev: RTL and testbench

GENIE_CONV_REV -- requirements
Module: genie_conv_rev

---
 rtl/genie_pkg.sv | 12 +
 rtl/genie_conv_rev_match.sv | 29 ++
 rtl/genie_conv_rev.sv | 175 +++++++++++++++++
 tb/tb_genie_conv_rev.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/genie_pkg.sv
// Shared types for the genie field-conversion blocks.
package genie_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

    localparam logic [7:0] MISS_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/genie_conv_rev_match.sv
// Combinational reverse lookup: converted field -> original field, plus miss flag.
module genie_conv_rev_match #(
    parameter int WIDTH_IN  = 0,
    parameter int WIDTH_OUT = 0,
    parameter int N_ENTRIES = 0,
    parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  IN_VALS  = '0,
    parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] OUT_VALS = '0
) (
    input  logic [WIDTH_OUT-1:0] i_field,
    output logic [WIDTH_IN-1:0]  o_field,
    output logic                 o_miss
);

    logic any_hit;

    // OR of all matches; with unique OUT_VALS at most one entry contributes.
    always_comb begin
        o_field = '0;
        any_hit = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (i_field == OUT_VALS[i]) begin
                o_field = o_field | IN_VALS[i];
                any_hit = 1'b1;
            end
        end
        o_miss = !any_hit;
    end

endmodule

// File: rtl/genie_conv_rev.sv
// Reverse field converter with a 2-entry skid buffer and registered ready.
module genie_conv_rev
    import genie_pkg::*;
#(
    parameter int WIDTH_IN   = 0,
    parameter int WIDTH_OUT  = 0,
    parameter int N_ENTRIES  = 0,
    parameter logic [N_ENTRIES-1:0][WIDTH_IN-1:0]  IN_VALS  = '0,
    parameter logic [N_ENTRIES-1:0][WIDTH_OUT-1:0] OUT_VALS = '0,
    parameter int WIDTH_DATA = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIDTH_OUT-1:0]  i_field,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic                  i_eop,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [WIDTH_IN-1:0]   o_field,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_eop,
    output logic                  o_miss,
    output logic [7:0]            o_miss_count
);

    logic [WIDTH_IN-1:0] m_field;
    logic                m_miss;

    genie_conv_rev_match #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .N_ENTRIES (N_ENTRIES),
        .IN_VALS   (IN_VALS),
        .OUT_VALS  (OUT_VALS)
    ) u_match (
        .i_field (i_field),
        .o_field (m_field),
        .o_miss  (m_miss)
    );

    buf_state_e            state_q, state_d;
    logic                  o_valid_q, o_valid_d;
    logic                  o_ready_q, o_ready_d;
    logic [WIDTH_IN-1:0]   o_field_q, o_field_d;
    logic [WIDTH_DATA-1:0] o_data_q, o_data_d;
    logic                  o_eop_q, o_eop_d;
    logic                  o_miss_q, o_miss_d;
    logic [7:0]            miss_count_q, miss_count_d;
    logic [WIDTH_IN-1:0]   skid_field_q, skid_field_d;
    logic [WIDTH_DATA-1:0] skid_data_q, skid_data_d;
    logic                  skid_eop_q, skid_eop_d;
    logic                  skid_miss_q, skid_miss_d;

    logic accept, deliver;
    assign accept  = i_valid && o_ready_q;
    assign deliver = o_valid_q && i_ready;

    // The head entry is the output register; the skid entry only fills on a stalled accept.
    always_comb begin
        state_d      = state_q;
        o_field_d    = o_field_q;
        o_data_d     = o_data_q;
        o_eop_d      = o_eop_q;
        o_miss_d     = o_miss_q;
        skid_field_d = skid_field_q;
        skid_data_d  = skid_data_q;
        skid_eop_d   = skid_eop_q;
        skid_miss_d  = skid_miss_q;
        miss_count_d = miss_count_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    o_field_d = m_field;
                    o_data_d  = i_data;
                    o_eop_d   = i_eop;
                    o_miss_d  = m_miss;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    o_field_d = m_field;
                    o_data_d  = i_data;
                    o_eop_d   = i_eop;
                    o_miss_d  = m_miss;
                end else if (deliver) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    skid_field_d = m_field;
                    skid_data_d  = i_data;
                    skid_eop_d   = i_eop;
                    skid_miss_d  = m_miss;
                    state_d      = FULL;
                end
            end
            FULL: begin
                if (deliver) begin
                    o_field_d = skid_field_q;
                    o_data_d  = skid_data_q;
                    o_eop_d   = skid_eop_q;
                    o_miss_d  = skid_miss_q;
                    state_d   = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (accept && m_miss && (miss_count_q != MISS_COUNT_MAX))
            miss_count_d = miss_count_q + 8'd1;

        o_valid_d = (state_d != EMPTY);
        o_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            o_valid_q    <= 1'b0;
            o_ready_q    <= 1'b0;
            o_field_q    <= '0;
            o_data_q     <= '0;
            o_eop_q      <= 1'b0;
            o_miss_q     <= 1'b0;
            miss_count_q <= '0;
            skid_field_q <= '0;
            skid_data_q  <= '0;
            skid_eop_q   <= 1'b0;
            skid_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_valid_q    <= o_valid_d;
            o_ready_q    <= o_ready_d;
            o_field_q    <= o_field_d;
            o_data_q     <= o_data_d;
            o_eop_q      <= o_eop_d;
            o_miss_q     <= o_miss_d;
            miss_count_q <= miss_count_d;
            skid_field_q <= skid_field_d;
            skid_data_q  <= skid_data_d;
            skid_eop_q   <= skid_eop_d;
            skid_miss_q  <= skid_miss_d;
        end
    end

    assign o_valid      = o_valid_q;
    assign o_ready      = o_ready_q;
    assign o_field      = o_field_q;
    assign o_data       = o_data_q;
    assign o_eop        = o_eop_q;
    assign o_miss       = o_miss_q;
    assign o_miss_count = miss_count_q;

`ifndef SYNTHESIS
    function automatic bit out_vals_unique();
        for (int i = 0; i < N_ENTRIES; i++)
            for (int j = i + 1; j < N_ENTRIES; j++)
                if (OUT_VALS[i] == OUT_VALS[j]) return 1'b0;
        return 1'b1;
    endfunction

    localparam bit OUT_UNIQUE = out_vals_unique();

    always_ff @(posedge clk) begin
        if (reset) assert (OUT_UNIQUE) else $error("genie_conv_rev: OUT_VALS entries not unique");
    end

    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (o_valid && !i_ready) |=> (o_valid && $stable(o_field) && $stable(o_data)
                                   && $stable(o_eop) && $stable(o_miss)));
`endif

endmodule

// File: tb/tb_genie_conv_rev.sv
// Directed bench for genie_conv_rev using the 3-entry reference table.
module tb_genie_conv_rev;

    localparam int WI = 4;
    localparam int WO = 8;
    localparam int N  = 3;
    localparam int WD = 8;
    localparam logic [N-1:0][WI-1:0] T_IN  = {4'h3, 4'h2, 4'h1};
    localparam logic [N-1:0][WO-1:0] T_OUT = {8'h30, 8'h21, 8'h12};

    logic          clk = 1'b0;
    logic          reset;
    logic          i_valid;
    logic          o_ready;
    logic [WO-1:0] i_field;
    logic [WD-1:0] i_data;
    logic          i_eop;
    logic          o_valid;
    logic          i_ready;
    logic [WI-1:0] o_field;
    logic [WD-1:0] o_data;
    logic          o_eop;
    logic          o_miss;
    logic [7:0]    o_miss_count;

    int checks   = 0;
    int failures = 0;

    genie_conv_rev #(
        .WIDTH_IN   (WI),
        .WIDTH_OUT  (WO),
        .N_ENTRIES  (N),
        .IN_VALS    (T_IN),
        .OUT_VALS   (T_OUT),
        .WIDTH_DATA (WD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_field      (i_field),
        .i_data       (i_data),
        .i_eop        (i_eop),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_field      (o_field),
        .o_data       (o_data),
        .o_eop        (o_eop),
        .o_miss       (o_miss),
        .o_miss_count (o_miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [WO-1:0] f, input logic [WD-1:0] d, input logic e);
        i_valid = v;
        i_field = f;
        i_data  = d;
        i_eop   = e;
    endtask

    initial begin
        reset   = 1'b1;
        i_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_ready", o_ready, 0);
        check("rst_count", o_miss_count, 0);
        check("rst_field", o_field, 0);
        check("rst_data",  o_data, 0);
        check("rst_eop",   o_eop, 0);
        check("rst_miss",  o_miss, 0);

        reset = 1'b0;
        tick();
        check("post_rst_ready", o_ready, 1);
        check("post_rst_valid", o_valid, 0);

        // back-to-back with downstream always ready
        i_ready = 1'b1;
        drive(1'b1, 8'h12, 8'hA1, 1'b0);
        tick();
        check("b2b0_valid", o_valid, 1);
        check("b2b0_field", o_field, 4'h1);
        check("b2b0_data",  o_data, 8'hA1);
        check("b2b0_miss",  o_miss, 0);
        drive(1'b1, 8'h21, 8'hA2, 1'b0);
        tick();
        check("b2b1_field", o_field, 4'h2);
        check("b2b1_data",  o_data, 8'hA2);
        check("b2b1_ready", o_ready, 1);
        drive(1'b1, 8'h30, 8'hA3, 1'b1);
        tick();
        check("b2b2_field", o_field, 4'h3);
        check("b2b2_eop",   o_eop, 1);
        check("b2b2_miss",  o_miss, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check("b2b_drain_valid", o_valid, 0);

        // stall: fill both entries, then release
        i_ready = 1'b0;
        drive(1'b1, 8'h21, 8'hB1, 1'b0);
        tick();
        check("st1_valid", o_valid, 1);
        check("st1_ready", o_ready, 1);
        check("st1_field", o_field, 4'h2);
        drive(1'b1, 8'h12, 8'hB2, 1'b1);
        tick();
        check("st2_ready", o_ready, 0);
        check("st2_field", o_field, 4'h2);
        check("st2_data",  o_data, 8'hB1);
        drive(1'b1, 8'h30, 8'hB3, 1'b0);
        tick();
        check("st3_hold_field", o_field, 4'h2);
        check("st3_hold_data",  o_data, 8'hB1);
        check("st3_ready", o_ready, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        i_ready = 1'b1;
        tick();
        check("st4_field", o_field, 4'h1);
        check("st4_data",  o_data, 8'hB2);
        check("st4_eop",   o_eop, 1);
        check("st4_ready", o_ready, 1);
        check("st4_valid", o_valid, 1);
        tick();
        check("st5_valid", o_valid, 0);
        check("st5_count", o_miss_count, 0);

        // single miss
        drive(1'b1, 8'hFF, 8'h5C, 1'b1);
        tick();
        check("miss_field", o_field, 0);
        check("miss_flag",  o_miss, 1);
        check("miss_count", o_miss_count, 1);
        check("miss_data",  o_data, 8'h5C);
        check("miss_eop",   o_eop, 1);

        // saturation: 300 misses total
        drive(1'b1, 8'hFF, 8'h00, 1'b0);
        for (int k = 0; k < 253; k++) tick();
        check("sat_254", o_miss_count, 254);
        tick();
        check("sat_255", o_miss_count, 255);
        for (int k = 0; k < 45; k++) tick();
        check("sat_300", o_miss_count, 255);
        drive(1'b1, 8'h12, 8'h77, 1'b0);
        tick();
        check("sat_hit_miss",  o_miss, 0);
        check("sat_hit_field", o_field, 4'h1);
        check("sat_hit_count", o_miss_count, 255);

        // reset while FULL
        i_ready = 1'b0;
        drive(1'b1, 8'h21, 8'hC1, 1'b0);
        tick();
        drive(1'b1, 8'h30, 8'hC2, 1'b0);
        tick();
        check("mr_full_ready", o_ready, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        reset = 1'b1;
        tick();
        check("mr_valid", o_valid, 0);
        check("mr_count", o_miss_count, 0);
        check("mr_ready", o_ready, 0);
        reset = 1'b0;
        tick();
        check("mr_post_ready", o_ready, 1);
        check("mr_post_valid", o_valid, 0);
        i_ready = 1'b1;
        drive(1'b1, 8'h30, 8'hD1, 1'b0);
        tick();
        check("mr_beat_field", o_field, 4'h3);
        check("mr_beat_data",  o_data, 8'hD1);
        check("mr_beat_count", o_miss_count, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
